npc_fetch_unit: RTL and testbench
=================================

# npc_fetch_unit

Parametrised next-PC block for the pipelined CPU's fetch stage. Holds the architectural fetch PC in a register and chooses the next PC from sequential fall-through, a branch-target-buffer (BTB) prediction, or an EX-stage redirect. The BTB is direct-mapped with 2-bit saturating counters and is trained by resolved branches and jumps from EX. Predictions travel down the pipeline with the instruction so EX can detect mispredicts.

## Interface

Parameters:
- RESET_PC, 32'h0000_3000, fetch address loaded at reset.
- BTB_DEPTH, 16, number of BTB entries; power of two, 2..256.
- BTB_IDX_W, $clog2(BTB_DEPTH), index width; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall  in  1  hold the PC (F/D stall from the hazard unit).
- redirect_valid  in  1  EX-stage mispredict or jr correction.
- redirect_pc  in  32  corrected fetch address.
- upd_valid  in  1  EX resolved a control-transfer instruction this cycle.
- upd_pc  in  32  PC of the resolved instruction.
- upd_taken  in  1  resolved direction.
- upd_target  in  32  resolved target (valid when upd_taken=1).
- pc  out  32  current fetch PC, registered.
- pred_taken  out  1  BTB predicts taken for pc.
- pred_target  out  32  predicted next PC for pc (target or pc+4).

## Operation

- BTB entry fields: valid, tag = PC[31:BTB_IDX_W+2], target[31:2], cnt[1:0].
- Lookup, combinational on pc: idx = pc[BTB_IDX_W+1:2]. hit = valid & (tag match). pred_taken = hit & cnt[1]. pred_target = pred_taken ? {target,2'b00} : pc+4.
- Next-PC priority, highest first:
  - redirect_valid: {redirect_pc[31:2],2'b00}.
  - stall: pc.
  - otherwise: pred_target.
- redirect_valid overrides stall.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000. Bits [1:0] of every PC source are forced to 0.
- BTB update, when upd_valid=1, at entry upd_pc[BTB_IDX_W+1:2]:
  - Hit, taken: cnt saturating increment (max 2'b11); target <= upd_target[31:2].
  - Hit, not taken: cnt saturating decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate (replace). valid=1, tag from upd_pc, target=upd_target[31:2], cnt=2'b10.
  - Miss, not taken: no change.
- Updates are independent of stall and redirect_valid.

## Timing

- Reset asserted (asynchronous), all of the following take effect immediately:
  - pc=RESET_PC.
  - All valid bits cleared; all cnt=2'b01.
  - Hence pred_taken=0 and pred_target=RESET_PC+4.
- Reset release: the first fetch is RESET_PC. pc changes on the first rising edge after reset deasserts.
- Reset asserted mid-operation aborts any update in flight. No partial BTB write survives.
- pc updates one cycle after next-PC selection: next-PC is combinational, registered on the rising clk edge.
- pred_taken and pred_target are combinational from pc and BTB state, with zero latency.
- A BTB update is written at the rising edge. It is visible to lookups from the following cycle.
- Same-cycle lookup and update of the same index: the lookup sees the pre-update contents.
- Redirect latency: redirect_valid in cycle N gives pc=redirect_pc in cycle N+1.

## Configuration

- Macro NPC_BTB_EN.
- Defined: BTB instantiated as described above.
- Undefined:
  - No BTB storage.
  - pred_taken is tied to 0 and pred_target = pc+4 (static predict-not-taken).
  - upd_* inputs are ignored.
  - Redirect and stall behaviour is unchanged.

## Test plan

- Reset and sequential fetch: hold reset=0, then release. Required: pc=32'h3000 while reset is held; then 32'h3004, 32'h3008 on successive edges, with pred_taken=0 throughout.
- Stall vs redirect: stall=1 for 2 cycles at pc=32'h3010 keeps pc at 32'h3010. Then stall=1 with redirect_valid=1 and redirect_pc=32'h3403. Required: next pc=32'h3400.
- BTB train and predict (NPC_BTB_EN defined): upd_valid=1, upd_pc=32'h3020, upd_taken=1, upd_target=32'h3100. Then redirect to 32'h3020. Required: pred_taken=1 and pred_target=32'h3100, with next pc=32'h3100.
- Counter hysteresis:
  - After the allocation above, one not-taken update on 32'h3020 gives cnt 2'b01, so pred_taken=0 and pred_target=32'h3024.
  - A further not-taken update saturates cnt at 2'b00.
  - Two taken updates bring pred_taken back to 1.
- Alias/tag miss (BTB_DEPTH=16): train 32'h3020 as taken to 32'h3100, then fetch 32'h3060 (same idx, different tag). Required: pred_taken=0 and next pc=32'h3064. Train 32'h3060 as taken to 32'h3200; then lookup of 32'h3020 misses.
- Wrap and same-cycle update: redirect to 32'hFFFF_FFFC, giving next pc=32'h0000_0000. Separately, an update at the same index as the current pc in cycle N leaves that cycle's pred_* unchanged; the new prediction appears when the lookup is repeated in cycle N+1.

Source files
------------

// File: rtl/npc_fetch_unit.sv
// Fetch-stage next-PC unit: PC register, redirect/stall/prediction select, direct-mapped BTB.
// Build option NPC_BTB_EN: defined builds the 2-bit-counter BTB; undefined gives static predict-not-taken.
module npc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int unsigned BTB_DEPTH = 16,
  parameter int unsigned BTB_IDX_W = $clog2(BTB_DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] pc,
  output logic        pred_taken,
  output logic [31:0] pred_target
);

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  logic [31:0] r_pc;
  logic [31:0] w_seq_pc;
  logic [31:0] w_next_pc;

  assign pc       = r_pc;
  assign w_seq_pc = r_pc + 32'd4;

`ifdef NPC_BTB_EN
  localparam int unsigned TAG_W = 30 - BTB_IDX_W;

  logic                 r_valid [BTB_DEPTH];
  logic [TAG_W-1:0]     r_tag   [BTB_DEPTH];
  logic [29:0]          r_tgt   [BTB_DEPTH];
  logic [1:0]           r_cnt   [BTB_DEPTH];
  logic [BTB_IDX_W-1:0] w_lk_idx;
  logic [BTB_IDX_W-1:0] w_up_idx;
  logic                 w_lk_hit;
  logic                 w_up_hit;
  logic                 w_unused_lsb;

  assign w_lk_idx    = r_pc[BTB_IDX_W+1:2];
  assign w_lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == r_pc[31:BTB_IDX_W+2]);
  assign pred_taken  = w_lk_hit && r_cnt[w_lk_idx][1];
  assign pred_target = pred_taken ? {r_tgt[w_lk_idx], 2'b00} : w_seq_pc;

  assign w_up_idx     = upd_pc[BTB_IDX_W+1:2];
  assign w_up_hit     = r_valid[w_up_idx] && (r_tag[w_up_idx] == upd_pc[31:BTB_IDX_W+2]);
  assign w_unused_lsb = ^{redirect_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  // Lookup reads the arrays before this edge's write lands, so same-index updates show next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < BTB_DEPTH; i++) begin
        r_valid[i[BTB_IDX_W-1:0]] <= 1'b0;
        r_tag[i[BTB_IDX_W-1:0]]   <= '0;
        r_tgt[i[BTB_IDX_W-1:0]]   <= '0;
        r_cnt[i[BTB_IDX_W-1:0]]   <= 2'b01;
      end
    end else if (upd_valid) begin
      if (w_up_hit) begin
        if (upd_taken) begin
          r_cnt[w_up_idx] <= (r_cnt[w_up_idx] == 2'b11) ? 2'b11 : r_cnt[w_up_idx] + 2'd1;
          r_tgt[w_up_idx] <= upd_target[31:2];
        end else begin
          r_cnt[w_up_idx] <= (r_cnt[w_up_idx] == 2'b00) ? 2'b00 : r_cnt[w_up_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        r_valid[w_up_idx] <= 1'b1;
        r_tag[w_up_idx]   <= upd_pc[31:BTB_IDX_W+2];
        r_tgt[w_up_idx]   <= upd_target[31:2];
        r_cnt[w_up_idx]   <= 2'b10;
      end
    end
  end
`else
  localparam int unsigned unused_btb_idx_w = BTB_IDX_W;

  logic w_unused_upd;

  assign pred_taken   = 1'b0;
  assign pred_target  = w_seq_pc;
  assign w_unused_upd = ^{upd_valid, upd_pc, upd_taken, upd_target, redirect_pc[1:0]};
`endif

  always_comb begin
    w_next_pc = pred_target;
    if (redirect_valid) begin
      w_next_pc = {redirect_pc[31:2], 2'b00};
    end else if (stall) begin
      w_next_pc = r_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC_AL;
    end else begin
      r_pc <= w_next_pc;
    end
  end

endmodule

// File: tb/tb_npc_fetch_unit.sv
// Scoreboard bench for npc_fetch_unit: stimulus pushes model predictions, a negedge monitor compares.
module tb_npc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int unsigned DEPTH  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  npc_fetch_unit #(
    .RESET_PC (RST_PC),
    .BTB_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .pc            (pc),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   errors = 0;
  int   checks = 0;

  // Reference model: fetch address plus a table of known branches keyed by (index, upper address).
  logic [31:0] m_pc;
`ifdef NPC_BTB_EN
  bit          m_valid [DEPTH];
  int unsigned m_tagv  [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  int          m_cnt   [DEPTH];

  function automatic int unsigned m_idx(input logic [31:0] a);
    return (a / 4) % DEPTH;
  endfunction

  function automatic int unsigned m_tag(input logic [31:0] a);
    return a / (4 * DEPTH);
  endfunction
`endif

  task automatic model_reset();
    m_pc = RST_PC & 32'hFFFF_FFFC;
`ifdef NPC_BTB_EN
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
    end
`endif
  endtask

  task automatic model_pred(output logic pt, output logic [31:0] tgt);
    pt  = 1'b0;
    tgt = m_pc + 32'd4;
`ifdef NPC_BTB_EN
    begin
      int unsigned ix;
      ix = m_idx(m_pc);
      if (m_valid[ix] && m_tagv[ix] == m_tag(m_pc) && m_cnt[ix] >= 2) begin
        pt  = 1'b1;
        tgt = m_tgt[ix];
      end
    end
`endif
  endtask

  task automatic model_step();
    logic        pt;
    logic [31:0] tgt;
    logic [31:0] nxt;
    model_pred(pt, tgt);
    if (redirect_valid)  nxt = redirect_pc & 32'hFFFF_FFFC;
    else if (stall)      nxt = m_pc;
    else                 nxt = tgt;
`ifdef NPC_BTB_EN
    if (upd_valid) begin
      int unsigned ix;
      bit          hit;
      ix  = m_idx(upd_pc);
      hit = m_valid[ix] && m_tagv[ix] == m_tag(upd_pc);
      if (hit && upd_taken) begin
        m_cnt[ix] = (m_cnt[ix] + 1 > 3) ? 3 : m_cnt[ix] + 1;
        m_tgt[ix] = upd_target & 32'hFFFF_FFFC;
      end else if (hit) begin
        m_cnt[ix] = (m_cnt[ix] - 1 < 0) ? 0 : m_cnt[ix] - 1;
      end else if (upd_taken) begin
        m_valid[ix] = 1'b1;
        m_tagv[ix]  = m_tag(upd_pc);
        m_tgt[ix]   = upd_target & 32'hFFFF_FFFC;
        m_cnt[ix]   = 2;
      end
    end
`endif
    m_pc = nxt;
  endtask

  task automatic push_exp(input string nm);
    exp_t e;
    e.name = nm;
    e.pc   = m_pc;
    model_pred(e.pt, e.tgt);
    sb.push_back(e);
  endtask

  task automatic cycle(input string nm, input logic s, input logic rv, input logic [31:0] rpc,
                       input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utg);
    push_exp(nm);
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_taken      = ut;
    upd_target     = utg;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input string nm);
    cycle(nm, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Reset asserted between edges with an update pending; the model discards that update.
  task automatic do_reset(input string nm);
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    upd_valid = 1'b1; upd_pc = 32'h0000_3020; upd_taken = 1'b1; upd_target = 32'h0000_3300;
    reset = 1'b0;
    model_reset();
    push_exp(nm);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      checks += 3;
      if (pc !== m_e.pc) begin
        errors++;
        $display("FAIL %s pc: got %h want %h", m_e.name, pc, m_e.pc);
      end
      if (pred_taken !== m_e.pt) begin
        errors++;
        $display("FAIL %s pred_taken: got %b want %b", m_e.name, pred_taken, m_e.pt);
      end
      if (pred_target !== m_e.tgt) begin
        errors++;
        $display("FAIL %s pred_target: got %h want %h", m_e.name, pred_target, m_e.tgt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  logic [31:0] pool [8] = '{32'h0000_3000, 32'h0000_3020, 32'h0000_3060, 32'h0000_3100,
                            32'h0000_3200, 32'h0000_30A0, 32'hFFFF_FFF8, 32'h0000_0040};

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0; upd_target = 32'h0;
    model_reset();
    @(posedge clk);
    #1;

    do_reset("reset_hold");
    idle("seq_3000"); idle("seq_3004"); idle("seq_3008");
    cycle("redir_3010", 0, 1, 32'h0000_3010, 0, 0, 0, 0);
    cycle("stall_a", 1, 0, 0, 0, 0, 0, 0);
    cycle("stall_b", 1, 0, 0, 0, 0, 0, 0);
    cycle("stall_redir", 1, 1, 32'h0000_3403, 0, 0, 0, 0);
    idle("redir_3400");

    cycle("train_3020", 0, 0, 0, 1, 32'h0000_3020, 1, 32'h0000_3100);
    cycle("redir_3020", 0, 1, 32'h0000_3020, 0, 0, 0, 0);
    idle("pred_hit");
    idle("pred_follow");

    cycle("redir_3020b", 0, 1, 32'h0000_3020, 0, 0, 0, 0);
    cycle("hyst_nt1", 1, 0, 0, 1, 32'h0000_3020, 0, 0);
    cycle("hyst_nt2", 1, 0, 0, 1, 32'h0000_3020, 0, 0);
    cycle("hyst_t1", 1, 0, 0, 1, 32'h0000_3020, 1, 32'h0000_3100);
    cycle("hyst_t2", 1, 0, 0, 1, 32'h0000_3020, 1, 32'h0000_3100);
    idle("hyst_back");
    idle("hyst_follow");

    cycle("alias_train", 0, 1, 32'h0000_3060, 1, 32'h0000_3020, 1, 32'h0000_3100);
    cycle("alias_look", 1, 0, 0, 0, 0, 0, 0);
    idle("alias_hold");
    idle("alias_seq");
    cycle("alias_train2", 0, 1, 32'h0000_3020, 1, 32'h0000_3060, 1, 32'h0000_3200);
    idle("alias_miss");
    idle("alias_seq2");

    cycle("wrap_redir", 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    idle("wrap_top");
    idle("wrap_zero");
    idle("wrap_four");

    for (int i = 0; i < 600; i++) begin
      logic        s, rv, uv, ut;
      logic [31:0] rpc, upc, utg;
      if (i == 300) do_reset("reset_midrun");
      s   = ($urandom % 4) == 0;
      rv  = ($urandom % 6) == 0;
      rpc = (($urandom % 4) == 0) ? $urandom : (pool[$urandom % 8] | ($urandom % 4));
      uv  = ($urandom % 5) < 2;
      upc = (($urandom % 3) == 0) ? m_pc : pool[$urandom % 8];
      ut  = ($urandom % 3) != 0;
      utg = pool[$urandom % 8] + ($urandom % 8) * 4 + ($urandom % 4);
      cycle("random", s, rv, rpc, uv, upc, ut, utg);
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
